// File: rtl/rename_free_list.sv
`default_nettype none
// ============================================================================
// Module   : rename_free_list
// Purpose  : Circular free list of physical-register tags for a rename stage.
//            Multi-lane all-or-nothing allocation (first-word-fall-through),
//            compacted multi-lane release, and read-pointer rewind for
//            misprediction recovery, with sticky overflow/revert error flags.
// Revision : 1.0 - initial release
// ============================================================================
module rename_free_list #(
  parameter int WIDTH      = 6,
  parameter int DEPTH      = 64,
  parameter int ALLOC_W    = 2,
  parameter int FREE_W     = 2,
  parameter int INIT_BASE  = 32,
  parameter int INIT_COUNT = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [$clog2(ALLOC_W+1)-1:0]    alloc_cnt,
  output logic                            alloc_grant,
  output logic [ALLOC_W*WIDTH-1:0]        alloc_tag,
  input  logic [FREE_W-1:0]               free_valid,
  input  logic [FREE_W*WIDTH-1:0]         free_tag,
  input  logic                            revert,
  input  logic [$clog2(DEPTH+1)-1:0]      revert_cnt,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            empty,
  output logic                            full,
  output logic                            err_overflow,
  output logic                            err_revert
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Extra headroom so occupancy sums never wrap before comparison.
  localparam int XW = CW + 2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr;

  logic [XW-1:0]     cnt_x;
  logic [XW-1:0]     alloc_x;
  logic [XW-1:0]     space_x;
  logic [XW-1:0]     nfree_x;
  logic [XW-1:0]     acc_x;
  logic [XW-1:0]     rev_x;
  logic [XW-1:0]     lane_pre [FREE_W];
  logic [FREE_W-1:0] lane_ok;
  logic              rev_ok;
  logic              overflow;

  // Grant, free-lane compaction/acceptance and revert acceptance, all from registered count.
  always_comb begin
    cnt_x       = XW'(count);
    alloc_grant = !revert && (alloc_cnt != '0) && (XW'(alloc_cnt) <= cnt_x);
    alloc_x     = alloc_grant ? XW'(alloc_cnt) : '0;
    space_x     = XW'(DEPTH) - cnt_x + alloc_x;
    nfree_x     = '0;
    acc_x       = '0;
    lane_ok     = '0;
    for (int k = 0; k < FREE_W; k++) begin
      lane_pre[k] = nfree_x;
      lane_ok[k]  = free_valid[k] && (nfree_x < space_x);
      if (lane_ok[k])    acc_x   = acc_x + XW'(1);
      if (free_valid[k]) nfree_x = nfree_x + XW'(1);
    end
    overflow = (nfree_x > space_x);
    rev_ok   = revert && ((XW'(revert_cnt) + cnt_x + acc_x) <= XW'(DEPTH));
    rev_x    = rev_ok ? XW'(revert_cnt) : '0;
  end

  // Tag storage: preload the initial tag range on reset, write accepted frees compacted from w_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < INIT_COUNT) ? WIDTH'(INIT_BASE + i) : '0;
      end
    end else begin
      for (int k = 0; k < FREE_W; k++) begin
        if (lane_ok[k]) begin
          mem[w_ptr + PW'(lane_pre[k])] <= free_tag[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Pointers, occupancy and sticky error flags; revert outranks allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      w_ptr        <= PW'(INIT_COUNT % DEPTH);
      count        <= CW'(INIT_COUNT);
      err_overflow <= 1'b0;
      err_revert   <= 1'b0;
    end else begin
      if (rev_ok) begin
        r_ptr <= r_ptr - PW'(revert_cnt);
      end else if (alloc_grant) begin
        r_ptr <= r_ptr + PW'(alloc_cnt);
      end
      w_ptr        <= w_ptr + PW'(acc_x);
      count        <= CW'(cnt_x - alloc_x + acc_x + rev_x);
      err_overflow <= err_overflow | overflow;
      err_revert   <= err_revert | (revert & ~rev_ok);
    end
  end

  // First-word-fall-through view of the next ALLOC_W entries.
  for (genvar k = 0; k < ALLOC_W; k++) begin : g_alloc
    assign alloc_tag[k*WIDTH +: WIDTH] = mem[r_ptr + PW'(k)];
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_rename_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_free_list
// Purpose  : Self-checking bench for rename_free_list: directed vector table,
//            hand-written corner sequences and a randomized run against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename_free_list;

  localparam int WIDTH   = 6;
  localparam int DEPTH   = 64;
  localparam int ALLOC_W = 2;
  localparam int FREE_W  = 2;
  localparam int CW      = 7;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [1:0]                alloc_cnt = '0;
  logic                      alloc_grant;
  logic [ALLOC_W*WIDTH-1:0]  alloc_tag;
  logic [FREE_W-1:0]         free_valid = '0;
  logic [FREE_W*WIDTH-1:0]   free_tag = '0;
  logic                      revert = 1'b0;
  logic [CW-1:0]             revert_cnt = '0;
  logic [CW-1:0]             count;
  logic                      empty, full, err_overflow, err_revert;

  rename_free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_cnt    (alloc_cnt),
    .alloc_grant  (alloc_grant),
    .alloc_tag    (alloc_tag),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .revert       (revert),
    .revert_cnt   (revert_cnt),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .err_overflow (err_overflow),
    .err_revert   (err_revert)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the free list as an ordered queue of tags, plus the
  // history of handed-out tags so a rewind can return the most recent ones.
  int fl[$];
  int hist[$];
  bit m_ovf;
  bit m_rev;

  typedef struct {
    logic [1:0]  ac;
    logic [1:0]  fv;
    logic [11:0] ft;
    logic        rv;
    logic [6:0]  rc;
    logic        eg;
    int          ec;
    int          et0;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int tag_of(input int k);
    return int'(alloc_tag[k*WIDTH +: WIDTH]);
  endfunction

  task automatic drive(input int ac, input int fv, input int t0, input int t1,
                       input int rv, input int rc);
    alloc_cnt  = 2'(ac);
    free_valid = 2'(fv);
    free_tag   = {6'(t1), 6'(t0)};
    revert     = 1'(rv);
    revert_cnt = 7'(rc);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fl.delete();
    hist.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
    m_ovf = 1'b0;
    m_rev = 1'b0;
  endtask

  // Compare DUT against the model for the current inputs, then advance the model.
  task automatic model_step();
    int sz;
    int ac;
    int space;
    int nfree;
    int acc;
    bit g;
    bit rok;
    int t;
    sz    = fl.size();
    ac    = int'(alloc_cnt);
    g     = !revert && (ac > 0) && (ac <= sz);
    space = DEPTH - sz + (g ? ac : 0);
    nfree = 0;
    for (int k = 0; k < FREE_W; k++) nfree += int'(free_valid[k]);
    acc   = (nfree < space) ? nfree : space;
    rok   = revert && ((int'(revert_cnt) + sz + acc) <= DEPTH);
    chk("rnd_grant", int'(alloc_grant), int'(g));
    chk("rnd_count", int'(count), sz);
    chk("rnd_empty", int'(empty), int'(sz == 0));
    chk("rnd_full", int'(full), int'(sz == DEPTH));
    chk("rnd_err_ovf", int'(err_overflow), int'(m_ovf));
    chk("rnd_err_rev", int'(err_revert), int'(m_rev));
    for (int k = 0; k < ALLOC_W; k++) begin
      if (k < sz) chk("rnd_tag", tag_of(k), fl[k]);
    end
    if (g) begin
      for (int j = 0; j < ac; j++) begin
        t = fl.pop_front();
        hist.push_back(t);
      end
    end
    if (rok) begin
      for (int j = 0; j < int'(revert_cnt); j++) begin
        t = hist.pop_back();
        fl.push_front(t);
      end
    end
    t = 0;
    for (int k = 0; k < FREE_W; k++) begin
      if (free_valid[k]) begin
        if (t < space) fl.push_back(int'(free_tag[k*WIDTH +: WIDTH]));
        t++;
      end
    end
    if (nfree > space) m_ovf = 1'b1;
    if (revert && !rok) m_rev = 1'b1;
  endtask

  initial begin
    // ---------------- directed vector table (from reset) ----------------
    tbl[0] = '{2'd0, 2'b00, 12'd0, 1'b0, 7'd0, 1'b0, 32, 32};
    tbl[1] = '{2'd2, 2'b00, 12'd0, 1'b0, 7'd0, 1'b1, 32, 32};
    tbl[2] = '{2'd2, 2'b00, 12'd0, 1'b1, 7'd2, 1'b0, 30, 34};
    tbl[3] = '{2'd0, 2'b00, 12'd0, 1'b0, 7'd0, 1'b0, 32, 32};
    tbl[4] = '{2'd1, 2'b00, 12'd0, 1'b0, 7'd0, 1'b1, 32, 32};
    tbl[5] = '{2'd2, 2'b01, 12'd7, 1'b0, 7'd0, 1'b1, 31, 33};
    tbl[6] = '{2'd0, 2'b00, 12'd0, 1'b0, 7'd0, 1'b0, 30, 35};
    tbl[7] = '{2'd1, 2'b00, 12'd0, 1'b1, 7'd0, 1'b0, 30, 35};

    do_reset();
    chk("reset_tag1", tag_of(1), 33);
    chk("reset_empty", int'(empty), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_err_ovf", int'(err_overflow), 0);
    chk("reset_err_rev", int'(err_revert), 0);
    for (int i = 0; i < 8; i++) begin
      alloc_cnt  = tbl[i].ac;
      free_valid = tbl[i].fv;
      free_tag   = tbl[i].ft;
      revert     = tbl[i].rv;
      revert_cnt = tbl[i].rc;
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", i), int'(alloc_grant), int'(tbl[i].eg));
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].ec);
      chk($sformatf("tbl%0d_tag0", i), tag_of(0), tbl[i].et0);
      @(posedge clk);
      #1;
    end

    // ---------------- drain to empty, then grant refused ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(2, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("drain_grant", int'(alloc_grant), 1);
      chk("drain_tag0", tag_of(0), 32 + 2 * i);
      chk("drain_tag1", tag_of(1), 33 + 2 * i);
      @(posedge clk);
      #1;
    end
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("empty_count", int'(count), 0);
    chk("empty_flag", int'(empty), 1);
    chk("empty_grant", int'(alloc_grant), 0);
    @(posedge clk);
    #1;
    // Release on lane1 alongside a request: not allocatable this cycle.
    drive(1, 2'b10, 0, 5, 0, 0);
    @(negedge clk);
    chk("bypass_grant", int'(alloc_grant), 0);
    chk("bypass_count", int'(count), 0);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("refill_count", int'(count), 1);
    chk("refill_grant", int'(alloc_grant), 1);
    chk("refill_tag0", tag_of(0), 5);
    @(posedge clk);
    #1;

    // ---------------- fill to full, overflow and rejected revert ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(0, 2'b11, 2 * i, 2 * i + 1, 0, 0);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_flag", int'(full), 1);
    chk("full_count", int'(count), 64);
    chk("full_err_ovf_clear", int'(err_overflow), 0);
    @(posedge clk);
    #1;
    drive(0, 2'b11, 9, 10, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_count", int'(count), 64);
    chk("ovf_flag", int'(err_overflow), 1);
    chk("ovf_rev_clear", int'(err_revert), 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 1, 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rev_rej_flag", int'(err_revert), 1);
    chk("rev_rej_count", int'(count), 64);
    chk("ovf_sticky", int'(err_overflow), 1);
    @(posedge clk);
    #1;

    // ---------------- asynchronous reset mid-cycle ----------------
    do_reset();
    drive(2, 2'b01, 11, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_arst_count", int'(count), 30);
    rst_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 32);
    chk("arst_tag0", tag_of(0), 32);
    chk("arst_tag1", tag_of(1), 33);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int ac;
      int fv;
      int rv;
      int rc;
      ac = $urandom_range(0, 2);
      fv = $urandom_range(0, 3);
      rv = ($urandom_range(0, 9) == 0) ? 1 : 0;
      rc = $urandom_range(0, 4);
      if (rc > hist.size()) rc = hist.size();
      drive(ac, fv, $urandom_range(0, 63), $urandom_range(0, 63), rv, rc);
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
